// File: rtl/rx_frame_checker_pkg.sv
// rx_frame_checker_pkg: shared state encoding and constants for the RX frame checker
package rx_frame_checker_pkg;
  typedef enum logic [1:0] {IDLE, FRAME, DROP, TERM} state_t;
  localparam int LEN_W = 11;
  localparam logic [7:0] TERM_BYTE = 8'h00;
endpackage

// File: rtl/rx_frame_checker_sat_counter.sv
// sat_counter: 16-bit saturating counter advancing by a small step each cycle
module sat_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  step,
  output logic [15:0] q
);
  logic [16:0] sum;
  assign sum = {1'b0, q} + {15'b0, step};
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else q <= sum[16] ? '1 : sum[15:0];
endmodule

// File: rtl/rx_frame_checker.sv
// rx_frame_checker: length/error checking of MAC RX frames with overflow truncation
module rx_frame_checker
  import rx_frame_checker_pkg::*;
#(
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_tdata,
  input  logic        i_tvalid,
  input  logic        i_tlast,
  input  logic        i_tuser,
  output logic [7:0]  o_tdata,
  output logic        o_tvalid,
  output logic        o_tlast,
  output logic        o_tuser,
  input  logic        o_tready,
  output logic [15:0] ok_cnt,
  output logic [15:0] bad_cnt
);
  state_t state;
  logic [LEN_W-1:0] len, len_n;
  logic err, err_n, nf, owe, sync;
  logic free, take, close_bad;
  logic [1:0] ok_step, bad_step;
  assign free = !o_tvalid || o_tready;
  assign take = sync && (state == IDLE || state == FRAME) && i_tvalid;
  assign len_n = state == IDLE ? LEN_W'(1) : (&len ? len : len + 1'b1);
  assign err_n = (state == FRAME && err) || i_tuser;
  assign close_bad = err_n || 32'(len_n) < MIN_LEN || 32'(len_n) > MAX_LEN;
  assign ok_step = 2'(take && free && i_tlast && !close_bad);
  // a frame lost before any byte reached the slot is counted bad at the moment it is discarded
  assign bad_step = 2'(take && free && i_tlast && close_bad) + 2'(take && !free && state == IDLE)
                  + 2'(state == TERM && free) + 2'(state == TERM && i_tvalid && !nf);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      o_tvalid <= 1'b0;
      o_tdata <= '0;
      o_tlast <= 1'b0;
      o_tuser <= 1'b0;
      len <= '0;
      err <= 1'b0;
      nf <= 1'b0;
      owe <= 1'b0;
      sync <= 1'b0;
    end else begin
      if (o_tready) o_tvalid <= 1'b0;
      if (!sync) begin
        if (i_tvalid && i_tlast) sync <= 1'b1;
      end else
        case (state)
          IDLE, FRAME:
            if (i_tvalid) begin
              if (free) begin
                o_tvalid <= 1'b1;
                o_tdata <= i_tdata;
                o_tlast <= i_tlast;
                o_tuser <= i_tlast && close_bad;
                len <= len_n;
                err <= err_n;
                state <= i_tlast ? IDLE : FRAME;
              end else begin
                owe <= state == FRAME;
                state <= !i_tlast ? DROP : (state == FRAME ? TERM : IDLE);
              end
            end
          DROP:
            if (i_tvalid && i_tlast) state <= owe ? TERM : IDLE;
          TERM:
            if (free) begin
              o_tvalid <= 1'b1;
              o_tdata <= TERM_BYTE;
              o_tlast <= 1'b1;
              o_tuser <= 1'b1;
              owe <= 1'b0;
              nf <= 1'b0;
              state <= (i_tvalid ? !i_tlast : nf) ? DROP : IDLE;
            end else if (i_tvalid) nf <= !i_tlast;
          default: state <= IDLE;
        endcase
    end
  sat_counter u_ok (.clk(clk), .rst(rst), .step(ok_step), .q(ok_cnt));
  sat_counter u_bad (.clk(clk), .rst(rst), .step(bad_step), .q(bad_cnt));
endmodule
